// File: rtl/ov7670_pkg.sv
// -----------------------------------------------------------------------------
// ov7670_pkg
// Shared types and constants for the OV7670 parallel-bus capture block.
//   capture_state_t : frame-level capture FSM encoding
//   OV7670_VGA_*    : nominal VGA frame geometry of the sensor
//   DEF_*           : default parameter values used by the capture top
// -----------------------------------------------------------------------------
package ov7670_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    ACTIVE   = 2'd2
  } capture_state_t;

  localparam int unsigned OV7670_VGA_COLS = 640;
  localparam int unsigned OV7670_VGA_ROWS = 480;

  localparam int unsigned DEF_BYTES_PER_PIXEL = 1;
  localparam int unsigned DEF_SYNC_STAGES     = 2;
  localparam int unsigned DEF_COL_W           = 11;
  localparam int unsigned DEF_ROW_W           = 10;

endpackage

// File: rtl/ov7670_sync_edge.sv
// -----------------------------------------------------------------------------
// ov7670_sync_edge
// Multi-flop synchronizer for one camera control line, with single-cycle
// rise/fall pulses derived from the synchronized level.
// Ports:
//   clk      : system clock
//   reset_   : synchronous active-high reset
//   async_in : camera-domain level (treated as asynchronous data)
//   level    : synchronized level (last synchronizer flop)
//   rise_c   : combinational pulse, synchronized level went 0 -> 1
//   fall_c   : combinational pulse, synchronized level went 1 -> 0
// -----------------------------------------------------------------------------
module ov7670_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset_,
  input  logic async_in,
  output logic level,
  output logic rise_c,
  output logic fall_c
);

  logic [STAGES-1:0] chain;
  logic              prev;

  // Shift toward the MSB; the truncating cast keeps this valid for STAGES=1.
  always_ff @(posedge clk) begin
    if (reset_) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= STAGES'({chain, async_in});
      prev  <= chain[STAGES-1];
    end
  end

  assign level  = chain[STAGES-1];
  assign rise_c = level & ~prev;
  assign fall_c = ~level & prev;

endmodule

// File: rtl/ov7670_pixel_capture.sv
// -----------------------------------------------------------------------------
// ov7670_pixel_capture
// Samples the OV7670 parallel video bus in the system clock domain, assembles
// bytes into pixels and emits them as AXI-Stream (tuser = start of frame,
// tlast = end of line). Pixels run one behind the bus: a pixel is parked in a
// one-deep hold register and pushed to the output by the next pixel, by HREF
// falling, or by VSYNC rising.
// Ports:
//   clk, reset_         : system clock (>= 3x PCLK), sync active-high reset
//   capture_en          : capture enable, sampled at VSYNC rising edges
//   cam_pclk/href/vsync : camera timing, synchronized internally
//   cam_d               : camera byte, synchronized with plain flops
//   test_mode           : (OV7670_CAPTURE_TEST_PATTERN_EN only) replace the
//                         byte with col[7:0] ^ row[7:0]
//   m_axis_*            : pixel stream
//   line_width          : pixel count of last completed line
//   frame_height        : line count of last completed frame
//   frame_count         : completed frames (wrapping)
//   overflow, line_err  : sticky error flags
// Optional build macro: OV7670_CAPTURE_TEST_PATTERN_EN
// -----------------------------------------------------------------------------
module ov7670_pixel_capture
  import ov7670_pkg::*;
#(
  parameter int unsigned BYTES_PER_PIXEL = DEF_BYTES_PER_PIXEL,
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned COL_W           = DEF_COL_W,
  parameter int unsigned ROW_W           = DEF_ROW_W
) (
  input  logic                         clk,
  input  logic                         reset_,
  input  logic                         capture_en,
  input  logic                         cam_pclk,
  input  logic                         cam_href,
  input  logic                         cam_vsync,
  input  logic [7:0]                   cam_d,
`ifdef OV7670_CAPTURE_TEST_PATTERN_EN
  input  logic                         test_mode,
`endif
  output logic [8*BYTES_PER_PIXEL-1:0] m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast,
  output logic                         m_axis_tuser,
  output logic [COL_W-1:0]             line_width,
  output logic [ROW_W-1:0]             frame_height,
  output logic [15:0]                  frame_count,
  output logic                         overflow,
  output logic                         line_err
);

  localparam int unsigned PIX_W = 8 * BYTES_PER_PIXEL;
  localparam int unsigned BC_W  = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1;

  // ---------------------------------------------------------------------------
  // Synchronizers
  // ---------------------------------------------------------------------------
  logic pclk_lvl, pclk_rise_c, pclk_fall_c;
  logic href_lvl, href_rise_c, href_fall_c;
  logic vs_lvl, vs_rise_c, vs_fall_c;
  logic [7:0] d_sync [SYNC_STAGES];

  ov7670_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_pclk (
    .clk(clk), .reset_(reset_), .async_in(cam_pclk),
    .level(pclk_lvl), .rise_c(pclk_rise_c), .fall_c(pclk_fall_c)
  );

  ov7670_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_href (
    .clk(clk), .reset_(reset_), .async_in(cam_href),
    .level(href_lvl), .rise_c(href_rise_c), .fall_c(href_fall_c)
  );

  ov7670_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_vsync (
    .clk(clk), .reset_(reset_), .async_in(cam_vsync),
    .level(vs_lvl), .rise_c(vs_rise_c), .fall_c(vs_fall_c)
  );

  logic unused_sync;
  assign unused_sync = ^{pclk_lvl, pclk_fall_c, href_rise_c, vs_lvl};

  // Data delay line matches the control synchronizer depth so the byte
  // lines up with the detected PCLK edge.
  always_ff @(posedge clk) begin
    if (reset_) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) d_sync[i] <= 8'h00;
    end else begin
      d_sync[0] <= cam_d;
      for (int i = 1; i < int'(SYNC_STAGES); i++) d_sync[i] <= d_sync[i-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Capture state
  // ---------------------------------------------------------------------------
  capture_state_t   state, state_next;
  logic             sof_pending;
  logic [BC_W-1:0]  byte_cnt;
  logic [PIX_W-1:0] acc;
  logic             hold_valid;
  logic             hold_user;
  logic [PIX_W-1:0] hold_data;
  logic [COL_W-1:0] cols;
  logic [ROW_W-1:0] rows;

  logic [7:0]       din_c;
  logic             active_c;
  logic             byte_take_c;
  logic             last_byte_c;
  logic             pix_done_c;
  logic [PIX_W-1:0] pixel_c;
  logic             eol_c;
  logic             eof_c;
  logic             push_c;
  logic             push_last_c;
  logic             out_free_c;
  logic             drop_c;
  logic             drop_frame_c;

`ifdef OV7670_CAPTURE_TEST_PATTERN_EN
  assign din_c = test_mode ? (8'(cols) ^ 8'(rows)) : d_sync[SYNC_STAGES-1];
`else
  assign din_c = d_sync[SYNC_STAGES-1];
`endif

  assign active_c    = (state == ACTIVE);
  assign byte_take_c = active_c & pclk_rise_c & href_lvl;
  assign last_byte_c = (byte_cnt == BC_W'(BYTES_PER_PIXEL - 1));
  assign pix_done_c  = byte_take_c & last_byte_c;
  // MSB-first shift; truncation drops the oldest byte.
  assign pixel_c     = PIX_W'({acc, din_c});
  assign eol_c       = active_c & href_fall_c;
  assign eof_c       = active_c & vs_rise_c;

  // Any of these events flushes the held pixel toward the output register.
  assign push_c       = hold_valid & (pix_done_c | eol_c | eof_c);
  assign push_last_c  = eol_c | eof_c;
  assign out_free_c   = ~m_axis_tvalid | m_axis_tready;
  assign drop_c       = push_c & ~out_free_c;
  assign drop_frame_c = drop_c & hold_user;

  // State register
  always_ff @(posedge clk) begin
    if (reset_) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (vs_rise_c && capture_en) state_next = WAIT_SOF;
      end
      WAIT_SOF: begin
        if (vs_fall_c) state_next = ACTIVE;
      end
      ACTIVE: begin
        // Losing the first pixel abandons the frame until the next SOF.
        if (drop_frame_c)   state_next = WAIT_SOF;
        else if (vs_rise_c) state_next = capture_en ? WAIT_SOF : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Byte assembly, hold register, counters and output register
  always_ff @(posedge clk) begin
    if (reset_) begin
      sof_pending   <= 1'b0;
      byte_cnt      <= '0;
      acc           <= '0;
      hold_valid    <= 1'b0;
      hold_user     <= 1'b0;
      hold_data     <= '0;
      cols          <= '0;
      rows          <= '0;
      line_width    <= '0;
      frame_height  <= '0;
      frame_count   <= 16'h0000;
      overflow      <= 1'b0;
      line_err      <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
    end else begin
      // Start of frame
      if (state == WAIT_SOF && vs_fall_c) begin
        sof_pending <= 1'b1;
        rows        <= '0;
        cols        <= '0;
        byte_cnt    <= '0;
        hold_valid  <= 1'b0;
      end

      // Byte capture
      if (byte_take_c) begin
        if (last_byte_c) begin
          byte_cnt    <= '0;
          hold_valid  <= 1'b1;
          hold_data   <= pixel_c;
          hold_user   <= sof_pending;
          sof_pending <= 1'b0;
          cols        <= (cols == '1) ? cols : cols + COL_W'(1);
        end else begin
          byte_cnt <= byte_cnt + BC_W'(1);
          acc      <= pixel_c;
        end
      end

      // End of line; partial pixels are discarded
      if (eol_c) begin
        hold_valid <= 1'b0;
        line_width <= cols;
        rows       <= (rows == '1) ? rows : rows + ROW_W'(1);
        cols       <= '0;
        byte_cnt   <= '0;
        if (byte_cnt != '0) line_err <= 1'b1;
      end

      // End of frame; a still-held pixel means HREF never fell
      if (eof_c) begin
        hold_valid   <= 1'b0;
        byte_cnt     <= '0;
        frame_height <= rows;
        if (hold_valid)    line_err    <= 1'b1;
        if (!drop_frame_c) frame_count <= frame_count + 16'd1;
      end

      if (drop_frame_c) begin
        hold_valid  <= 1'b0;
        byte_cnt    <= '0;
        sof_pending <= 1'b0;
      end

      // Output register; a dropped tlast is merged into the pending word
      if (push_c && out_free_c) begin
        m_axis_tdata  <= hold_data;
        m_axis_tvalid <= 1'b1;
        m_axis_tlast  <= push_last_c;
        m_axis_tuser  <= hold_user;
      end else if (drop_c) begin
        overflow <= 1'b1;
        if (push_last_c) m_axis_tlast <= 1'b1;
      end else if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ov7670_pixel_capture.sv
// -----------------------------------------------------------------------------
// tb_ov7670_pixel_capture
// Directed bench: one 1-byte-per-pixel instance and one 2-byte-per-pixel
// instance share the camera bus. Camera timing: clk period 10, PCLK period 40.
// Beats are recorded at the falling clk edge when tvalid & tready.
// -----------------------------------------------------------------------------
module tb_ov7670_pixel_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_;
  logic        capture_en;
  logic        cam_pclk, cam_href, cam_vsync;
  logic [7:0]  cam_d;
  logic        ready1, ready2;
`ifdef OV7670_CAPTURE_TEST_PATTERN_EN
  logic        test_mode;
`endif

  logic [7:0]  m1_tdata;
  logic        m1_tvalid, m1_tlast, m1_tuser;
  logic [10:0] lw1;
  logic [9:0]  fh1;
  logic [15:0] fc1;
  logic        ov1, le1;

  logic [15:0] m2_tdata;
  logic        m2_tvalid, m2_tlast, m2_tuser;
  logic [10:0] lw2;
  logic [9:0]  fh2;
  logic [15:0] fc2;
  logic        ov2, le2;

  ov7670_pixel_capture #(.BYTES_PER_PIXEL(1)) u1 (
    .clk(clk), .reset_(reset_), .capture_en(capture_en),
    .cam_pclk(cam_pclk), .cam_href(cam_href), .cam_vsync(cam_vsync), .cam_d(cam_d),
`ifdef OV7670_CAPTURE_TEST_PATTERN_EN
    .test_mode(test_mode),
`endif
    .m_axis_tdata(m1_tdata), .m_axis_tvalid(m1_tvalid), .m_axis_tready(ready1),
    .m_axis_tlast(m1_tlast), .m_axis_tuser(m1_tuser),
    .line_width(lw1), .frame_height(fh1), .frame_count(fc1),
    .overflow(ov1), .line_err(le1)
  );

  ov7670_pixel_capture #(.BYTES_PER_PIXEL(2)) u2 (
    .clk(clk), .reset_(reset_), .capture_en(capture_en),
    .cam_pclk(cam_pclk), .cam_href(cam_href), .cam_vsync(cam_vsync), .cam_d(cam_d),
`ifdef OV7670_CAPTURE_TEST_PATTERN_EN
    .test_mode(test_mode),
`endif
    .m_axis_tdata(m2_tdata), .m_axis_tvalid(m2_tvalid), .m_axis_tready(ready2),
    .m_axis_tlast(m2_tlast), .m_axis_tuser(m2_tuser),
    .line_width(lw2), .frame_height(fh2), .frame_count(fc2),
    .overflow(ov2), .line_err(le2)
  );

  // Beat recorders: {tdata, tlast, tuser}
  logic [9:0]  q1 [$];
  logic [17:0] q2 [$];

  always @(negedge clk) begin
    if (m1_tvalid === 1'b1 && ready1 === 1'b1) q1.push_back({m1_tdata, m1_tlast, m1_tuser});
    if (m2_tvalid === 1'b1 && ready2 === 1'b1) q2.push_back({m2_tdata, m2_tlast, m2_tuser});
  end

  int checks   = 0;
  int failures = 0;
  logic [7:0] lb [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] beat1(input int k);
    return (k < q1.size()) ? 32'(q1[k]) : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] beat2(input int k);
    return (k < q2.size()) ? 32'(q2[k]) : 32'hDEAD_BEEF;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset_ = 1'b1;
    tick(3);
    reset_ = 1'b0;
    tick(1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    cam_d    = b;
    cam_pclk = 1'b0;
    tick(2);
    cam_pclk = 1'b1;
    tick(2);
  endtask

  task automatic send_line(input int n);
    cam_href = 1'b1;
    for (int i = 0; i < n; i++) send_byte(lb[i]);
    cam_pclk = 1'b0;
    tick(2);
    cam_href = 1'b0;
    tick(6);
  endtask

  task automatic fill_line(input logic [7:0] base);
    for (int i = 0; i < 16; i++) lb[i] = 8'(int'(base) + i);
  endtask

  task automatic vs_high();
    cam_vsync = 1'b1;
    tick(8);
  endtask

  task automatic vs_low();
    cam_vsync = 1'b0;
    tick(8);
  endtask

  initial begin
    reset_     = 1'b1;
    capture_en = 1'b0;
    cam_pclk   = 1'b0;
    cam_href   = 1'b0;
    cam_vsync  = 1'b0;
    cam_d      = 8'h00;
    ready1     = 1'b1;
    ready2     = 1'b1;
`ifdef OV7670_CAPTURE_TEST_PATTERN_EN
    test_mode  = 1'b0;
`endif

    // ---- Reset state ----
    do_reset();
    check("rst_stream1", 32'({m1_tdata, m1_tvalid, m1_tlast, m1_tuser}), 32'h0);
    check("rst_stats1", 32'({lw1, fh1}), 32'h0);
    check("rst_fc1", 32'(fc1), 32'h0);
    check("rst_flags1", 32'({ov1, le1}), 32'h0);
    check("rst_stream2", 32'({m2_tdata, m2_tvalid, m2_tlast, m2_tuser}), 32'h0);

    // ---- 1 B/px: 4 lines x 8 bytes, tready=1 ----
    capture_en = 1'b1;
    vs_high();
    vs_low();
    for (int l = 0; l < 4; l++) begin
      fill_line(8'(l * 16));
      send_line(8);
    end
    vs_high();
    check("p1_beats", 32'(q1.size()), 32'd32);
    for (int k = 0; k < 32; k++)
      check("p1_beat", beat1(k),
            32'({8'((k / 8) * 16 + (k % 8)), (k % 8) == 7, k == 0}));
    check("p1_line_width", 32'(lw1), 32'd8);
    check("p1_frame_height", 32'(fh1), 32'd4);
    check("p1_frame_count", 32'(fc1), 32'd1);
    check("p1_flags", 32'({ov1, le1}), 32'h0);
    vs_low();

    // ---- 2 B/px: AB CD 12 34 56 -> two pixels, partial byte dropped ----
    do_reset();
    q2.delete();
    vs_high();
    vs_low();
    lb[0] = 8'hAB; lb[1] = 8'hCD; lb[2] = 8'h12; lb[3] = 8'h34; lb[4] = 8'h56;
    send_line(5);
    vs_high();
    check("p2_beats", 32'(q2.size()), 32'd2);
    check("p2_beat0", beat2(0), 32'({16'hABCD, 1'b0, 1'b1}));
    check("p2_beat1", beat2(1), 32'({16'h1234, 1'b1, 1'b0}));
    check("p2_line_err", 32'(le2), 32'd1);
    check("p2_line_width", 32'(lw2), 32'd2);
    check("p2_frame", 32'({fh2, fc2}), 32'({10'd1, 16'd1}));
    check("p2_overflow", 32'(ov2), 32'd0);
    vs_low();

    // ---- Backpressure: tready=0 for a whole 8-pixel line ----
    do_reset();
    q1.delete();
    ready1 = 1'b0;
    vs_high();
    vs_low();
    fill_line(8'h10);
    send_line(8);
    tick(2);
    check("p3_word", 32'({m1_tvalid, m1_tdata, m1_tlast, m1_tuser}),
          32'({1'b1, 8'h10, 1'b1, 1'b1}));
    check("p3_overflow", 32'(ov1), 32'd1);
    check("p3_no_beats", 32'(q1.size()), 32'd0);
    tick(5);
    check("p3_stable", 32'({m1_tvalid, m1_tdata, m1_tlast, m1_tuser}),
          32'({1'b1, 8'h10, 1'b1, 1'b1}));
    ready1 = 1'b1;
    tick(2);
    check("p3_one_beat", 32'(q1.size()), 32'd1);
    check("p3_beat0", beat1(0), 32'({8'h10, 1'b1, 1'b1}));
    check("p3_drained", 32'(m1_tvalid), 32'd0);
    check("p3_line_err", 32'(le1), 32'd0);
    vs_high();
    vs_low();

    // ---- capture_en gating ----
    do_reset();
    q1.delete();
    check("p4_ovf_cleared", 32'(ov1), 32'd0);
    capture_en = 1'b0;
    vs_high();
    vs_low();
    fill_line(8'h20);
    send_line(8);
    vs_high();
    check("p4_off_beats", 32'(q1.size()), 32'd0);
    check("p4_off_fc", 32'(fc1), 32'd0);
    vs_low();
    capture_en = 1'b1;
    vs_high();
    vs_low();
    capture_en = 1'b0;
    fill_line(8'h30);
    send_line(8);
    vs_high();
    check("p4_mid_beats", 32'(q1.size()), 32'd8);
    check("p4_mid_first", beat1(0), 32'({8'h30, 1'b0, 1'b1}));
    check("p4_mid_last", beat1(7), 32'({8'h37, 1'b1, 1'b0}));
    check("p4_mid_fc", 32'(fc1), 32'd1);
    vs_low();
    send_line(8);
    vs_high();
    check("p4_next_absent", 32'(q1.size()), 32'd8);
    check("p4_next_fc", 32'(fc1), 32'd1);
    vs_low();

    // ---- Reset mid-line ----
    q1.delete();
    capture_en = 1'b1;
    vs_high();
    vs_low();
    cam_href = 1'b1;
    for (int i = 0; i < 4; i++) send_byte(8'(8'h40 + i));
    cam_pclk = 1'b0;
    tick(4);
    reset_ = 1'b1;
    tick(1);
    check("p5_rst_stream", 32'({m1_tdata, m1_tvalid, m1_tlast, m1_tuser}), 32'h0);
    check("p5_rst_stats", 32'({lw1, fh1}), 32'h0);
    check("p5_rst_fc", 32'(fc1), 32'h0);
    reset_ = 1'b0;
    for (int i = 4; i < 8; i++) send_byte(8'(8'h40 + i));
    cam_pclk = 1'b0;
    tick(2);
    cam_href = 1'b0;
    tick(6);
    fill_line(8'h60);
    send_line(8);
    check("p5_idle_beats", 32'(q1.size()), 32'd3);
    vs_high();
    vs_low();
    fill_line(8'h50);
    send_line(8);
    vs_high();
    check("p5_resume_beats", 32'(q1.size()), 32'd11);
    check("p5_resume_first", beat1(3), 32'({8'h50, 1'b0, 1'b1}));
    check("p5_resume_last", beat1(10), 32'({8'h57, 1'b1, 1'b0}));
    check("p5_resume_fc", 32'({fc1, lw1}), 32'({16'd1, 11'd8}));

`ifdef OV7670_CAPTURE_TEST_PATTERN_EN
    // ---- Test pattern: row 2, col 5 -> 0x07 ----
    test_mode = 1'b1;
    vs_low();
    for (int l = 0; l < 3; l++) send_line(8);
    vs_high();
    check("tp_r2c5", beat1(11 + 21), 32'({8'h07, 1'b0, 1'b0}));
    test_mode = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
